// File: rtl/wb_arbiter2_pkg.sv
// Shared bus-block constants: arbiter FSM encoding and reset/default bus values.
package wb_arbiter2_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Wide enough for any bus in the codebase; users slice down to their width.
  localparam logic [63:0] DATA_ONES = '1;
  localparam logic [2:0]  SEL_RESET = 3'b010;

endpackage

// File: rtl/wb_req_hold.sv
// Per-master request holding register: accepts one stb pulse, holds its fields
// and stalls the master until the arbiter reports completion.
module wb_req_hold
  import wb_arbiter2_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_stb,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  input  logic [2:0]    i_sel,
  input  logic          i_done,
  output logic          o_stall,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic [2:0]    o_sel
);

  logic          stall_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] data_reg;
  logic [2:0]    sel_reg;

  // Stall doubles as the pending flag: set on accept, cleared on the ack edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_reg <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= DATA_ONES[AW-1:0];
      data_reg  <= DATA_ONES[DW-1:0];
      sel_reg   <= SEL_RESET;
    end else if (i_done) begin
      stall_reg <= 1'b0;
    end else if (i_stb && !stall_reg) begin
      stall_reg <= 1'b1;
      we_reg    <= i_we;
      addr_reg  <= i_addr;
      data_reg  <= i_data;
      sel_reg   <= i_sel;
    end
  end

  assign o_stall = stall_reg;
  assign o_we    = we_reg;
  assign o_addr  = addr_reg;
  assign o_data  = data_reg;
  assign o_sel   = sel_reg;

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with alternating tie-break and a
// slave-ack timeout so a dead slave cannot hang the cpu.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_m0_stb,
  input  logic          i_m1_stb,
  input  logic          i_m0_we,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m0_data,
  input  logic [DW-1:0] i_m1_data,
  input  logic [2:0]    i_m0_sel,
  input  logic [2:0]    i_m1_sel,
  output logic          o_m0_stall,
  output logic          o_m1_stall,
  output logic          o_m0_ack,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m0_data,
  output logic [DW-1:0] o_m1_data,
  output logic          o_s_stb,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_data,
  output logic [2:0]    o_s_sel,
  input  logic          i_s_stall,
  input  logic          i_s_ack,
  input  logic [DW-1:0] i_s_data,
  output logic          o_timeout,
  output logic          o_grant
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          m_stb  [2];
  logic          m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  logic [2:0]    m_sel  [2];

  logic [1:0]    pend;
  logic [1:0]    done;
  logic          h_we   [2];
  logic [AW-1:0] h_addr [2];
  logic [DW-1:0] h_data [2];
  logic [2:0]    h_sel  [2];

  assign m_stb[0]  = i_m0_stb;   assign m_stb[1]  = i_m1_stb;
  assign m_we[0]   = i_m0_we;    assign m_we[1]   = i_m1_we;
  assign m_addr[0] = i_m0_addr;  assign m_addr[1] = i_m1_addr;
  assign m_data[0] = i_m0_data;  assign m_data[1] = i_m1_data;
  assign m_sel[0]  = i_m0_sel;   assign m_sel[1]  = i_m1_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hold
      wb_req_hold #(.AW(AW), .DW(DW)) u_hold (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_stb    (m_stb[gi]),
        .i_we     (m_we[gi]),
        .i_addr   (m_addr[gi]),
        .i_data   (m_data[gi]),
        .i_sel    (m_sel[gi]),
        .i_done   (done[gi]),
        .o_stall  (pend[gi]),
        .o_we     (h_we[gi]),
        .o_addr   (h_addr[gi]),
        .o_data   (h_data[gi]),
        .o_sel    (h_sel[gi])
      );
    end
  endgenerate

  state_t        state_reg, state_next;
  logic          grant_reg, grant_next;
  logic          s_stb_reg, s_stb_next;
  logic          s_we_reg, s_we_next;
  logic [AW-1:0] s_addr_reg, s_addr_next;
  logic [DW-1:0] s_data_reg, s_data_next;
  logic [2:0]    s_sel_reg, s_sel_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    ack_reg, ack_next;
  logic [DW-1:0] mdata_reg [2];
  logic [DW-1:0] mdata_next [2];
  logic          timeout_reg, timeout_next;
  logic          winner;

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    s_stb_next    = 1'b0;
    s_we_next     = s_we_reg;
    s_addr_next   = s_addr_reg;
    s_data_next   = s_data_reg;
    s_sel_next    = s_sel_reg;
    cnt_next      = cnt_reg;
    ack_next      = 2'b00;
    mdata_next[0] = mdata_reg[0];
    mdata_next[1] = mdata_reg[1];
    timeout_next  = 1'b0;
    done          = 2'b00;
    winner        = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (pend != 2'b00 && !i_s_stall) begin
          // On a tie the master that did not own the last transaction wins.
          winner      = (pend == 2'b11) ? ~grant_reg : pend[1];
          grant_next  = winner;
          s_stb_next  = 1'b1;
          s_we_next   = h_we[winner];
          s_addr_next = h_addr[winner];
          s_data_next = h_data[winner];
          s_sel_next  = h_sel[winner];
          cnt_next    = '0;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_s_ack) begin
          ack_next[grant_reg]   = 1'b1;
          mdata_next[grant_reg] = i_s_data;
          done[grant_reg]       = 1'b1;
          state_next            = S_IDLE;
        end else if (TIMEOUT != 0 && cnt_reg == CNT_LAST) begin
          ack_next[grant_reg]   = 1'b1;
          mdata_next[grant_reg] = DATA_ONES[DW-1:0];
          timeout_next          = 1'b1;
          done[grant_reg]       = 1'b1;
          state_next            = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg    <= S_IDLE;
      grant_reg    <= 1'b0;
      s_stb_reg    <= 1'b0;
      s_we_reg     <= 1'b0;
      s_addr_reg   <= DATA_ONES[AW-1:0];
      s_data_reg   <= DATA_ONES[DW-1:0];
      s_sel_reg    <= SEL_RESET;
      cnt_reg      <= '0;
      ack_reg      <= 2'b00;
      mdata_reg[0] <= DATA_ONES[DW-1:0];
      mdata_reg[1] <= DATA_ONES[DW-1:0];
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      s_stb_reg    <= s_stb_next;
      s_we_reg     <= s_we_next;
      s_addr_reg   <= s_addr_next;
      s_data_reg   <= s_data_next;
      s_sel_reg    <= s_sel_next;
      cnt_reg      <= cnt_next;
      ack_reg      <= ack_next;
      mdata_reg[0] <= mdata_next[0];
      mdata_reg[1] <= mdata_next[1];
      timeout_reg  <= timeout_next;
    end
  end

  assign o_m0_stall = pend[0];
  assign o_m1_stall = pend[1];
  assign o_m0_ack   = ack_reg[0];
  assign o_m1_ack   = ack_reg[1];
  assign o_m0_data  = mdata_reg[0];
  assign o_m1_data  = mdata_reg[1];
  assign o_s_stb    = s_stb_reg;
  assign o_s_we     = s_we_reg;
  assign o_s_addr   = s_addr_reg;
  assign o_s_data   = s_data_reg;
  assign o_s_sel    = s_sel_reg;
  assign o_timeout  = timeout_reg;
  assign o_grant    = grant_reg;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 (TIMEOUT=4) with a one-wait slave responder.
module tb_wb_arbiter2;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_m0_stb, i_m1_stb, i_m0_we, i_m1_we;
  logic [31:0] i_m0_addr, i_m1_addr, i_m0_data, i_m1_data;
  logic [2:0]  i_m0_sel, i_m1_sel;
  logic        o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack;
  logic [31:0] o_m0_data, o_m1_data;
  logic        o_s_stb, o_s_we;
  logic [31:0] o_s_addr, o_s_data;
  logic [2:0]  o_s_sel;
  logic        i_s_stall, i_s_ack;
  logic [31:0] i_s_data;
  logic        o_timeout, o_grant;

  always #5 i_clk = ~i_clk;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m0_stb(i_m0_stb), .i_m1_stb(i_m1_stb),
    .i_m0_we(i_m0_we), .i_m1_we(i_m1_we),
    .i_m0_addr(i_m0_addr), .i_m1_addr(i_m1_addr),
    .i_m0_data(i_m0_data), .i_m1_data(i_m1_data),
    .i_m0_sel(i_m0_sel), .i_m1_sel(i_m1_sel),
    .o_m0_stall(o_m0_stall), .o_m1_stall(o_m1_stall),
    .o_m0_ack(o_m0_ack), .o_m1_ack(o_m1_ack),
    .o_m0_data(o_m0_data), .o_m1_data(o_m1_data),
    .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_addr(o_s_addr),
    .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_data(i_s_data),
    .o_timeout(o_timeout), .o_grant(o_grant)
  );

  int n_vec = 0, n_err = 0;
  int stb_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, both_ack = 0;
  int base_stb, base_a0, base_a1;
  bit slave_en = 1'b1, force_ack = 1'b0, stb_prev = 1'b0;
  logic [31:0] slave_rdata = 32'h0;

  // Slave answers one cycle after its stb; also tallies bus events.
  always @(negedge i_clk) begin
    i_s_ack  = (slave_en && stb_prev) || force_ack;
    i_s_data = slave_rdata;
    stb_prev = o_s_stb;
    stb_cnt  += int'(o_s_stb);
    ack0_cnt += int'(o_m0_ack);
    ack1_cnt += int'(o_m1_ack);
    both_ack += int'(o_m0_ack && o_m1_ack);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic snap();
    base_stb = stb_cnt;
    base_a0  = ack0_cnt;
    base_a1  = ack1_cnt;
  endtask

  task automatic m0_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    i_m0_stb = 1'b1; i_m0_we = we; i_m0_addr = addr; i_m0_data = data; i_m0_sel = 3'b001;
  endtask

  task automatic m1_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    i_m1_stb = 1'b1; i_m1_we = we; i_m1_addr = addr; i_m1_data = data; i_m1_sel = 3'b100;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_m0_stb = 0; i_m1_stb = 0; i_m0_we = 0; i_m1_we = 0;
    i_m0_addr = 0; i_m1_addr = 0; i_m0_data = 0; i_m1_data = 0;
    i_m0_sel = 0; i_m1_sel = 0; i_s_stall = 0; i_s_ack = 0; i_s_data = 0;
    tick(); tick();
    check("rst_s_stb", o_s_stb, 0);
    check("rst_stall", {o_m1_stall, o_m0_stall}, 0);
    check("rst_s_addr", o_s_addr, 32'hFFFF_FFFF);
    check("rst_s_data", o_s_data, 32'hFFFF_FFFF);
    check("rst_s_sel", o_s_sel, 3'b010);
    check("rst_grant", o_grant, 0);
    check("rst_m_data", {o_m1_data, o_m0_data}, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_timeout", o_timeout, 0);
    i_reset_n = 1'b1;
    tick();

    // Single m0 read
    slave_rdata = 32'hDEAD_BEEF;
    snap();
    m0_req(1'b0, 32'h10, 32'h0);
    tick(); i_m0_stb = 1'b0;
    check("t1_accept_stall", o_m0_stall, 1);
    check("t1_no_stb_yet", o_s_stb, 0);
    tick();
    check("t1_stb", o_s_stb, 1);
    check("t1_addr", o_s_addr, 32'h10);
    check("t1_we", o_s_we, 0);
    check("t1_sel", o_s_sel, 3'b001);
    check("t1_grant", o_grant, 0);
    tick();
    check("t1_stb_narrow", o_s_stb, 0);
    check("t1_stall_held", o_m0_stall, 1);
    tick();
    check("t1_ack", {o_m1_ack, o_m0_ack}, 2'b01);
    check("t1_rdata", o_m0_data, 32'hDEAD_BEEF);
    check("t1_stall_clr", {o_m1_stall, o_m0_stall}, 0);
    tick();
    check("t1_ack_1cyc", o_m0_ack, 0);
    check("t1_counts", {8'(stb_cnt - base_stb), 8'(ack0_cnt - base_a0), 8'(ack1_cnt - base_a1)}, 24'h010100);

    // Tie after reset goes to m1 first
    i_reset_n = 1'b0; tick(); i_reset_n = 1'b1; tick();
    slave_rdata = 32'hCAFE_0001;
    snap();
    m0_req(1'b1, 32'h20, 32'h11);
    m1_req(1'b0, 32'h30, 32'h0);
    tick(); i_m0_stb = 1'b0; i_m1_stb = 1'b0;
    check("t2_both_stall", {o_m1_stall, o_m0_stall}, 2'b11);
    tick();
    check("t2_grant_m1", o_grant, 1);
    check("t2_addr_m1", o_s_addr, 32'h30);
    tick(); tick();
    check("t2_ack_m1", {o_m1_ack, o_m0_ack}, 2'b10);
    check("t2_rdata_m1", o_m1_data, 32'hCAFE_0001);
    check("t2_stall_after", {o_m1_stall, o_m0_stall}, 2'b01);
    tick();
    check("t2_grant_m0", {o_s_stb, o_grant, o_s_we}, 3'b101);
    check("t2_wr_fields", {o_s_addr, o_s_data}, {32'h20, 32'h11});
    tick(); tick();
    check("t2_ack_m0", {o_m1_ack, o_m0_ack}, 2'b01);
    tick();
    check("t2_counts", {8'(stb_cnt - base_stb), 8'(ack0_cnt - base_a0), 8'(ack1_cnt - base_a1)}, 24'h020101);
    // m1 alone, then a tie which m0 must win
    m1_req(1'b0, 32'h34, 32'h0);
    tick(); i_m1_stb = 1'b0;
    tick(); tick(); tick(); tick();
    check("t2_m1_only_grant", o_grant, 1);
    m0_req(1'b0, 32'h24, 32'h0);
    m1_req(1'b0, 32'h38, 32'h0);
    tick(); i_m0_stb = 1'b0; i_m1_stb = 1'b0;
    tick();
    check("t2_tie_m0_wins", {o_grant, o_s_addr}, {1'b0, 32'h24});
    tick(); tick();
    check("t2_tie_ack_m0", {o_m1_ack, o_m0_ack}, 2'b01);
    tick();
    check("t2_tie_then_m1", {o_grant, o_s_addr}, {1'b1, 32'h38});
    tick(); tick();
    check("t2_tie_ack_m1", {o_m1_ack, o_m0_ack}, 2'b10);
    tick();

    // Slave stall holds off the stb
    slave_rdata = 32'h1234_5678;
    i_s_stall = 1'b1;
    m0_req(1'b0, 32'h44, 32'h0);
    tick(); i_m0_stb = 1'b0;
    snap();
    for (int i = 0; i < 5; i++) tick();
    check("t3_no_stb_stalled", stb_cnt - base_stb, 0);
    i_s_stall = 1'b0;
    tick();
    check("t3_stb_after_stall", {o_s_stb, o_s_addr}, {1'b1, 32'h44});
    tick(); tick();
    check("t3_ack", {o_m0_ack, o_m0_data}, {1'b1, 32'h1234_5678});
    tick();

    // Timeout with a dead slave
    slave_en = 1'b0;
    m0_req(1'b0, 32'h50, 32'h0);
    tick(); i_m0_stb = 1'b0;
    tick();
    check("t4_stb", o_s_stb, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wait_no_ack", {o_m0_ack, o_timeout}, 2'b00);
    end
    tick();
    check("t4_to_ack", {o_m0_ack, o_timeout, o_m0_stall}, 3'b110);
    check("t4_to_data", o_m0_data, 32'hFFFF_FFFF);
    tick();
    check("t4_to_pulse", {o_m0_ack, o_timeout}, 2'b00);
    snap();
    force_ack = 1'b1;
    tick(); tick();
    force_ack = 1'b0;
    tick(); tick();
    check("t4_late_ack_ignored", {8'(stb_cnt - base_stb), 8'(ack0_cnt - base_a0), 8'(ack1_cnt - base_a1)}, 24'h0);
    slave_en = 1'b1;
    slave_rdata = 32'hA5A5_0F0F;
    m0_req(1'b0, 32'h54, 32'h0);
    tick(); i_m0_stb = 1'b0;
    tick(); tick(); tick();
    check("t4_recover", {o_m0_ack, o_timeout, o_m0_data}, {2'b10, 32'hA5A5_0F0F});
    tick();

    // Asynchronous reset in mid-transaction
    slave_en = 1'b0;
    m1_req(1'b0, 32'h60, 32'h0);
    tick(); i_m1_stb = 1'b0;
    tick();
    check("t5_pre_rst", {o_s_stb, o_grant, o_m1_stall}, 3'b111);
    #2 i_reset_n = 1'b0;
    #1;
    check("t5_async_stb", {o_s_stb, o_grant, o_m1_stall}, 3'b000);
    check("t5_async_bus", {o_s_addr, o_s_sel}, {32'hFFFF_FFFF, 3'b010});
    slave_en = 1'b1;
    snap();
    tick(); tick();
    i_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_ack", {8'(ack0_cnt - base_a0), 8'(ack1_cnt - base_a1), 7'd0, o_m1_stall}, 24'h0);
    m0_req(1'b0, 32'h64, 32'h0);
    m1_req(1'b0, 32'h68, 32'h0);
    tick(); i_m0_stb = 1'b0; i_m1_stb = 1'b0;
    tick();
    check("t5_powerup_tie", {o_grant, o_s_addr}, {1'b1, 32'h68});
    for (int i = 0; i < 6; i++) tick();

    // Re-strobe while stalled is ignored
    snap();
    m0_req(1'b0, 32'h70, 32'h0);
    tick();
    i_m0_addr = 32'h74;
    tick(); tick();
    i_m0_stb = 1'b0;
    tick();
    check("t6_ack", o_m0_ack, 1);
    check("t6_orig_addr", o_s_addr, 32'h70);
    for (int i = 0; i < 3; i++) tick();
    check("t6_counts", {8'(stb_cnt - base_stb), 8'(ack0_cnt - base_a0), 8'(ack1_cnt - base_a1)}, 24'h010100);

    check("never_both_acks", both_ack, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
